// File: rtl/mux2to1_32_pkg.sv
// Shared IF-stage pipeline constants used by the PC-source select mux.
package mux2to1_32_pkg;

    localparam int unsigned XLEN = 32;

    // Encoding of the PC-source select: sequential fetch or taken branch.
    typedef enum logic {
        PC_SEL_SEQ = 1'b0,
        PC_SEL_BR  = 1'b1
    } pc_sel_e;

endpackage

// File: rtl/mux2to1_32_if.sv
// Bundle of the select/data signals for the PC-source mux.
// There is no handshake: inputs are sampled continuously (or on every clk edge when registered).
interface mux2to1_32_if
    import mux2to1_32_pkg::*;
#(
    parameter int unsigned WIDTH = XLEN
);

    logic             sel;
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] out;
    logic             out_sel;

    modport master (output sel, output in0, output in1, input out, input out_sel);
    modport slave  (input sel, input in0, input in1, output out, output out_sel);

endinterface

// File: rtl/mux2to1_32.sv
// Two-way word select used as the IF-stage PC-source mux.
// Optionally registers out/out_sel for timing closure (REG_OUT=1, async reset).
module mux2to1_32
    import mux2to1_32_pkg::*;
#(
    parameter int unsigned      WIDTH     = XLEN,
    parameter bit               REG_OUT   = 1'b0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic           clk,
    input  logic           rst,
    mux2to1_32_if.slave    bus
);

    logic [WIDTH-1:0] out_d;
    logic             out_sel_d;

    // Only a definite 1 selects the branch target; X/Z falls back to PC+4.
    always_comb begin
        out_sel_d = (bus.sel === PC_SEL_BR);
        out_d     = out_sel_d ? bus.in1 : bus.in0;
    end

    generate
        if (REG_OUT) begin : g_reg
            logic [WIDTH-1:0] out_q;
            logic             out_sel_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_q     <= RESET_VAL;
                    out_sel_q <= 1'b0;
                end else begin
                    out_q     <= out_d;
                    out_sel_q <= out_sel_d;
                end
            end

            assign bus.out     = out_q;
            assign bus.out_sel = out_sel_q;
        end else begin : g_comb
            logic unused_clk_rst;

            assign unused_clk_rst = &{1'b0, clk, rst};
            assign bus.out        = out_d;
            assign bus.out_sel    = out_sel_d;
        end
    endgenerate

endmodule

// File: tb/tb_mux2to1_32.sv
// Self-checking bench for mux2to1_32: one combinational and one registered instance.
module tb_mux2to1_32;
  import mux2to1_32_pkg::*;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  logic [32:0] exp_q[$];
  logic [32:0] last_exp;

  mux2to1_32_if #(.WIDTH(32)) c_if ();
  mux2to1_32_if #(.WIDTH(32)) r_if ();

  mux2to1_32 #(.WIDTH(32), .REG_OUT(1'b0), .RESET_VAL(32'h0)) u_comb (
    .clk (clk),
    .rst (rst),
    .bus (c_if)
  );

  mux2to1_32 #(.WIDTH(32), .REG_OUT(1'b1), .RESET_VAL(32'h0)) u_reg (
    .clk (clk),
    .rst (rst),
    .bus (r_if)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: word chosen by the select rule, with the taken flag on top.
  function automatic logic [32:0] ref_mux(logic s, logic [31:0] a, logic [31:0] b);
    if (s === 1'b1) return {1'b1, b};
    return {1'b0, a};
  endfunction

  task automatic check(string tag, logic [32:0] obs, logic [32:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic comb_step(string tag, logic s, logic [31:0] a, logic [31:0] b);
    c_if.sel = s;
    c_if.in0 = a;
    c_if.in1 = b;
    #1;
    check(tag, {c_if.out_sel, c_if.out}, ref_mux(s, a, b));
  endtask

  // Drive between edges, confirm the output has not moved yet, then check after the edge.
  task automatic reg_step(string tag, logic s, logic [31:0] a, logic [31:0] b);
    @(negedge clk);
    r_if.sel = s;
    r_if.in0 = a;
    r_if.in1 = b;
    exp_q.push_back(ref_mux(s, a, b));
    #1;
    check({tag, "_hold"}, {r_if.out_sel, r_if.out}, last_exp);
    @(posedge clk);
    #1;
    last_exp = exp_q.pop_front();
    check(tag, {r_if.out_sel, r_if.out}, last_exp);
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    last_exp = 33'h0;
    rst      = 1'b1;
    c_if.sel = 1'b0;
    c_if.in0 = 32'h0000_0004;
    c_if.in1 = 32'h0000_0100;
    r_if.sel = 1'b1;
    r_if.in0 = 32'h0000_0004;
    r_if.in1 = 32'h0000_0164;
    #1;

    // combinational: directed
    check("comb_sel0", {c_if.out_sel, c_if.out}, {1'b0, 32'h0000_0004});
    comb_step("comb_sel1", 1'b1, 32'h0000_0004, 32'h0000_0100);
    comb_step("comb_selx", 1'bx, 32'h0000_0004, 32'h0000_0100);
    comb_step("comb_sweep_ff", 1'b1, 32'h1234_5678, 32'hFFFF_FFFF);
    comb_step("comb_sweep_80", 1'b1, 32'hA5A5_A5A5, 32'h8000_0000);
    comb_step("comb_sweep_00", 1'b1, 32'hFFFF_FFFF, 32'h0000_0000);
    comb_step("comb_in0_only", 1'b1, 32'h0BAD_F00D, 32'h0000_0000);

    // combinational: random
    for (int i = 0; i < 24; i++) begin
      comb_step("comb_rand", 1'($urandom_range(0, 1)), 32'($urandom()), 32'($urandom()));
    end

    // registered: held in reset across clock edges
    @(negedge clk);
    check("reg_reset", {r_if.out_sel, r_if.out}, 33'h0);
    @(posedge clk);
    #1;
    check("reg_reset_edge", {r_if.out_sel, r_if.out}, 33'h0);

    // release reset with a taken branch pending: no update before the first edge
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reg_release_hold", {r_if.out_sel, r_if.out}, 33'h0);
    @(posedge clk);
    #1;
    last_exp = ref_mux(1'b1, 32'h0000_0004, 32'h0000_0164);
    check("reg_first_edge", {r_if.out_sel, r_if.out}, last_exp);

    // asynchronous reset between edges
    reg_step("reg_deadbeef", 1'b1, 32'h0000_0004, 32'hDEAD_BEEF);
    #2;
    rst = 1'b1;
    #1;
    check("reg_async_rst", {r_if.out_sel, r_if.out}, 33'h0);
    @(posedge clk);
    #1;
    check("reg_rst_edge", {r_if.out_sel, r_if.out}, 33'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reg_rst_release", {r_if.out_sel, r_if.out}, 33'h0);
    last_exp = 33'h0;
    @(posedge clk);
    #1;
    last_exp = ref_mux(1'b1, 32'h0000_0004, 32'hDEAD_BEEF);
    check("reg_after_rst", {r_if.out_sel, r_if.out}, last_exp);

    // alternating select, one-cycle lag
    for (int i = 0; i < 8; i++) begin
      reg_step("reg_alt", 1'(i % 2), 32'h0000_0008, 32'h0000_018C);
    end

    // X select through the register
    reg_step("reg_selx", 1'bx, 32'h0000_0040, 32'h0000_0080);

    // registered: random back-to-back
    for (int i = 0; i < 30; i++) begin
      reg_step("reg_rand", 1'($urandom_range(0, 1)), 32'($urandom()), 32'($urandom()));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
